// File: rtl/dfe_out_buffer.sv
// -----------------------------------------------------------------------------
// dfe_out_buffer
//
// Elastic output stage behind the DFE filter core. Every valid decimated
// sample from the core is captured into a circular FIFO. The FIFO is then
// presented to the downstream consumer through a first-word-fall-through
// valid/ready handshake. The block also keeps sticky status for core
// overflow/underflow and for dropped samples, plus a saturating drop counter.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   valid_in      sample strobe from the core (the core cannot be stalled)
//   data_in       signed sample from the core
//   ovf_in        core overflow flag, sampled every cycle
//   unf_in        core underflow flag, sampled every cycle
//   clear_status  one-cycle pulse; clears the sticky flags and drop_count
//   out_ready     consumer accepts the current sample
//   out_valid     out_data holds a valid sample
//   out_data      head-of-FIFO sample
//   fifo_count    occupancy, 0..FIFO_DEPTH
//   almost_full   fifo_count >= AF_THRESHOLD
//   drop_sticky   a sample was dropped since the last clear
//   ovf_sticky    ovf_in was seen high since the last clear
//   unf_sticky    unf_in was seen high since the last clear
//   drop_count    number of dropped samples, saturating at all-ones
// -----------------------------------------------------------------------------
module dfe_out_buffer #(
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int AF_THRESHOLD = 12,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          ovf_in,
    input  logic                          unf_in,
    input  logic                          clear_status,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          almost_full,
    output logic                          drop_sticky,
    output logic                          ovf_sticky,
    output logic                          unf_sticky,
    output logic [CNT_WIDTH-1:0]          drop_count
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    // Sticky flag slots: ovf, unf, drop share the same set-beats-clear rule.
    localparam int N_FLAGS  = 3;
    localparam int FLAG_OVF = 0;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_DRP = 2;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W-1:0]      count_reg;
    logic [PTR_W-1:0]      count_next;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [CNT_WIDTH-1:0]  drop_count_reg;
    logic [N_FLAGS-1:0]    flag_sticky_reg;
    logic [N_FLAGS-1:0]    flag_event;

    logic                  full;
    logic                  empty;
    logic                  rd;
    logic                  wr;
    logic                  drop;
    logic [ADDR_W-1:0]     rd_addr_next;
    logic                  head_from_input;
    logic                  head_from_mem;

    // Full when the pointers address the same slot but sit on opposite laps.
    assign full  = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                   (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);
    assign empty = (count_reg == '0);

    assign out_valid = !empty;
    assign rd        = out_valid && out_ready;
    // A read in the same cycle frees a slot, so a full FIFO still takes the write.
    assign wr        = valid_in && (!full || rd);
    assign drop      = valid_in && full && !rd;

    assign rd_addr_next = rd_ptr_reg[ADDR_W-1:0] + ADDR_W'(1);

    // The head sample lives in out_data_reg. It is refilled either straight
    // from data_in (the FIFO is empty or its last entry is leaving) or from
    // the slot behind the current head. That slot was written at least one
    // cycle earlier, so this is a plain registered RAM read.
    assign head_from_input = wr && (empty || ((count_reg == PTR_W'(1)) && rd));
    assign head_from_mem   = rd && (count_reg > PTR_W'(1));

    always_comb begin
        count_next = count_reg;
        case ({wr, rd})
            2'b10:   count_next = count_reg + PTR_W'(1);
            2'b01:   count_next = count_reg - PTR_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset, so it maps onto block RAM. Stale contents are
    // unreachable after a reset because the pointers and the count restart.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            out_data_reg <= '0;
        end else begin
            if (wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            if (head_from_input) begin
                out_data_reg <= data_in;
            end else if (head_from_mem) begin
                out_data_reg <= mem[rd_addr_next];
            end
        end
    end

    assign flag_event[FLAG_OVF] = ovf_in;
    assign flag_event[FLAG_UNF] = unf_in;
    assign flag_event[FLAG_DRP] = drop;

    // A clear in the same cycle as an event leaves the flag set.
    genvar gi;
    generate
        for (gi = 0; gi < N_FLAGS; gi++) begin : g_sticky
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    flag_sticky_reg[gi] <= 1'b0;
                end else if (clear_status) begin
                    flag_sticky_reg[gi] <= flag_event[gi];
                end else begin
                    flag_sticky_reg[gi] <= flag_sticky_reg[gi] | flag_event[gi];
                end
            end
        end
    endgenerate

    // A drop coinciding with clear_status restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_reg <= '0;
        end else if (clear_status) begin
            drop_count_reg <= drop ? CNT_WIDTH'(1) : '0;
        end else if (drop && (drop_count_reg != '1)) begin
            drop_count_reg <= drop_count_reg + CNT_WIDTH'(1);
        end
    end

    assign out_data    = out_data_reg;
    assign fifo_count  = count_reg;
    assign almost_full = (count_reg >= PTR_W'(AF_THRESHOLD));
    assign ovf_sticky  = flag_sticky_reg[FLAG_OVF];
    assign unf_sticky  = flag_sticky_reg[FLAG_UNF];
    assign drop_sticky = flag_sticky_reg[FLAG_DRP];
    assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_dfe_out_buffer.sv
// -----------------------------------------------------------------------------
// tb_dfe_out_buffer
//
// Directed and randomized stimulus for dfe_out_buffer. A queue-based reference
// model holds the expected FIFO contents, the sticky status and the drop count.
// Every cycle all DUT outputs are compared with the model.
// -----------------------------------------------------------------------------
module tb_dfe_out_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int CW    = 16;

    logic          clk;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          ovf_in;
    logic          unf_in;
    logic          clear_status;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [4:0]    fifo_count;
    logic          almost_full;
    logic          drop_sticky;
    logic          ovf_sticky;
    logic          unf_sticky;
    logic [CW-1:0] drop_count;

    dfe_out_buffer #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .AF_THRESHOLD(AF),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .ovf_in      (ovf_in),
        .unf_in      (unf_in),
        .clear_status(clear_status),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .fifo_count  (fifo_count),
        .almost_full (almost_full),
        .drop_sticky (drop_sticky),
        .ovf_sticky  (ovf_sticky),
        .unf_sticky  (unf_sticky),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_last;
    bit            m_ovf;
    bit            m_unf;
    bit            m_drop;
    int            m_dc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_q.delete();
        m_last = '0;
        m_ovf  = 0;
        m_unf  = 0;
        m_drop = 0;
        m_dc   = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid),   32'(m_q.size() > 0));
        chk({tag, ".data"},  32'(out_data),    32'(m_last));
        chk({tag, ".count"}, 32'(fifo_count),  32'(m_q.size()));
        chk({tag, ".af"},    32'(almost_full), 32'(m_q.size() >= AF));
        chk({tag, ".drop"},  32'(drop_sticky), 32'(m_drop));
        chk({tag, ".ovf"},   32'(ovf_sticky),  32'(m_ovf));
        chk({tag, ".unf"},   32'(unf_sticky),  32'(m_unf));
        chk({tag, ".dcnt"},  32'(drop_count),  32'(m_dc));
    endtask

    // One clock: the model decides from the inputs present at the edge,
    // then the DUT outputs are compared 1 time unit after the edge.
    task automatic step(input string tag);
        bit            rd_e;
        bit            full_e;
        bit            wr_e;
        bit            drop_e;
        logic [DW-1:0] d;
        bit            clr;
        rd_e   = (m_q.size() > 0) && out_ready;
        full_e = (m_q.size() == DEPTH);
        wr_e   = valid_in && (!full_e || rd_e);
        drop_e = valid_in && full_e && !rd_e;
        d      = data_in;
        clr    = clear_status;
        if (clr) begin
            m_ovf  = ovf_in;
            m_unf  = unf_in;
            m_drop = drop_e;
            m_dc   = drop_e ? 1 : 0;
        end else begin
            m_ovf  = m_ovf | ovf_in;
            m_unf  = m_unf | unf_in;
            m_drop = m_drop | drop_e;
            if (drop_e && m_dc != (1 << CW) - 1) m_dc++;
        end
        if (rd_e) void'(m_q.pop_front());
        if (wr_e) m_q.push_back(d);
        if (m_q.size() > 0) m_last = m_q[0];
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input string tag);
        valid_in  = v;
        data_in   = d;
        out_ready = r;
        step(tag);
    endtask

    initial begin
        rst          = 1'b1;
        valid_in     = 1'b0;
        data_in      = '0;
        ovf_in       = 1'b0;
        unf_in       = 1'b0;
        clear_status = 1'b0;
        out_ready    = 1'b0;
        reset_model();

        // Reset state
        #1;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset_held");
        rst = 1'b0;

        // In-order streaming with the consumer always ready
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, DW'(i), 1'b1, "stream");
            chk("stream.max1", 32'(fifo_count <= 1), 32'd1);
        end
        drive(1'b0, '0, 1'b1, "stream_tail");
        chk("stream.last", 32'(out_data), 32'h5);

        // Fill to full with the consumer stalled
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, DW'(16'h0100 + i), 1'b0, "fill");
            if (i == AF - 2) chk("fill.af_below", 32'(almost_full), 32'd0);
            if (i == AF - 1) chk("fill.af_at",    32'(almost_full), 32'd1);
        end
        chk("fill.count16", 32'(fifo_count), 32'd16);

        // Overflow write is dropped, the head is unchanged
        drive(1'b1, 16'hDEAD, 1'b0, "drop");
        chk("drop.sticky", 32'(drop_sticky), 32'd1);
        chk("drop.count1", 32'(drop_count), 32'd1);
        chk("drop.head",   32'(out_data), 32'h0100);

        // Drop coinciding with clear restarts the count at one
        clear_status = 1'b1;
        drive(1'b1, 16'hBEEF, 1'b0, "drop_clr");
        clear_status = 1'b0;
        chk("drop_clr.count", 32'(drop_count), 32'd1);

        // Full FIFO with a read and a write together: no drop
        drive(1'b1, 16'hABCD, 1'b1, "full_rw");
        chk("full_rw.count", 32'(fifo_count), 32'd16);
        chk("full_rw.dcnt",  32'(drop_count), 32'd1);
        for (int i = 0; i < 15; i++) drive(1'b0, '0, 1'b1, "drain");
        chk("drain.abcd_head", 32'(out_data), 32'hABCD);
        chk("drain.abcd_cnt",  32'(fifo_count), 32'd1);
        drive(1'b0, '0, 1'b1, "drain_last");

        // Consumer toggling ready while the core writes every 4th cycle
        for (int i = 0; i < 64; i++) begin
            drive((i % 4) == 0, DW'(16'h0200 + i), i[0], "toggle");
        end
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, "toggle_drain");

        // Status flags
        ovf_in = 1'b1;
        drive(1'b0, '0, 1'b1, "ovf_pulse");
        ovf_in = 1'b0;
        chk("ovf_pulse.sticky", 32'(ovf_sticky), 32'd1);
        drive(1'b0, '0, 1'b1, "ovf_hold");
        clear_status = 1'b1;
        drive(1'b0, '0, 1'b1, "clr_only");
        clear_status = 1'b0;
        chk("clr_only.ovf",  32'(ovf_sticky), 32'd0);
        chk("clr_only.dcnt", 32'(drop_count), 32'd0);
        clear_status = 1'b1;
        unf_in       = 1'b1;
        drive(1'b0, '0, 1'b1, "clr_unf");
        clear_status = 1'b0;
        unf_in       = 1'b0;
        chk("clr_unf.unf", 32'(unf_sticky), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int rdy_pct;
            rdy_pct      = (i < 200) ? 30 : ((i < 400) ? 70 : 50);
            ovf_in       = ($urandom_range(15) == 0);
            unf_in       = ($urandom_range(15) == 0);
            clear_status = ($urandom_range(31) == 0);
            drive($urandom_range(99) < 60, DW'($urandom), $urandom_range(99) < rdy_pct, "rand");
        end
        ovf_in       = 1'b0;
        unf_in       = 1'b0;
        clear_status = 1'b0;
        for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b1, "rand_drain");

        // Reset with 7 entries buffered
        for (int i = 0; i < 7; i++) drive(1'b1, DW'(16'h0300 + i), 1'b0, "pre_rst");
        valid_in = 1'b0;
        rst      = 1'b1;
        #1;
        reset_model();
        chk("rst_async.valid", 32'(out_valid),  32'd0);
        chk("rst_async.count", 32'(fifo_count), 32'd0);
        chk("rst_async.data",  32'(out_data),   32'd0);
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, DW'(16'h0400 + i), 1'b0, "post_rst");
        chk("post_rst.head",  32'(out_data),   32'h0400);
        chk("post_rst.count", 32'(fifo_count), 32'd3);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, "post_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
